// File: rtl/ap_hs_txn_profiler.sv
// rtl/ap_hs_txn_profiler.sv - ap_ctrl_hs transaction profiler with record FIFO
module ap_hs_txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int ITER_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_continue,
  input  logic              iter_fire,
  input  logic              finish,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [CNT_W-1:0]  rec_latency,
  output logic [CNT_W-1:0]  rec_ready_cyc,
  output logic [ITER_W-1:0] rec_iters,
  output logic [CNT_W-1:0]  rec_stall,
  output logic [CNT_W-1:0]  rec_wait,
  output logic              rec_incomplete,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
  localparam logic [ITER_W-1:0] I_ONE = ITER_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE_WAIT} state_t;

  typedef struct packed {
    logic              incomplete;
    logic [CNT_W-1:0]  wt;
    logic [CNT_W-1:0]  stall;
    logic [ITER_W-1:0] iters;
    logic [CNT_W-1:0]  rdy;
    logic [CNT_W-1:0]  lat;
  } rec_t;

  state_t state, state_nx;
  logic [CNT_W-1:0]  lat, lat_nx, rdy, rdy_nx, stall, stall_nx, wt, wt_nx;
  logic [ITER_W-1:0] iters, iters_nx;
  logic finished, finish_q, fin_rise;
  logic commit, incomplete;

  function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + C_ONE : v;
  endfunction

  function automatic logic [ITER_W-1:0] inc_i(input logic [ITER_W-1:0] v, input logic en);
    return (en && v != '1) ? v + I_ONE : v;
  endfunction

  assign fin_rise = finish & ~finish_q;
  assign busy     = (state != IDLE);

  // Commit records carry this cycle's updated counters, so the commit cycle is counted.
  always_comb begin
    state_nx   = state;
    lat_nx     = lat;
    rdy_nx     = rdy;
    iters_nx   = iters;
    stall_nx   = stall;
    wt_nx      = wt;
    commit     = 1'b0;
    incomplete = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start && !finished && !fin_rise) begin
          lat_nx   = C_ONE;
          rdy_nx   = ap_ready ? C_ONE : '0;
          iters_nx = iter_fire ? I_ONE : '0;
          stall_nx = iter_fire ? '0 : C_ONE;
          wt_nx    = '0;
          if (ap_done) begin
            if (ap_continue) begin
              commit = 1'b1;
            end else begin
              wt_nx    = C_ONE;
              state_nx = DONE_WAIT;
            end
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        lat_nx   = inc_c(lat, 1'b1);
        iters_nx = inc_i(iters, iter_fire);
        stall_nx = inc_c(stall, !iter_fire);
        if (ap_ready && rdy == '0) rdy_nx = lat_nx;
        if (ap_done) begin
          if (ap_continue) begin
            commit   = 1'b1;
            state_nx = IDLE;
          end else begin
            wt_nx    = C_ONE;
            state_nx = DONE_WAIT;
          end
        end
      end
      DONE_WAIT: begin
        wt_nx = inc_c(wt, 1'b1);
        if (ap_continue || !ap_done) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (fin_rise && state != IDLE) begin
      incomplete = !commit;
      commit     = 1'b1;
      state_nx   = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat      <= '0;
      rdy      <= '0;
      iters    <= '0;
      stall    <= '0;
      wt       <= '0;
      finished <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state    <= state_nx;
      lat      <= lat_nx;
      rdy      <= rdy_nx;
      iters    <= iters_nx;
      stall    <= stall_nx;
      wt       <= wt_nx;
      finish_q <= finish;
      if (fin_rise) finished <= 1'b1;
    end
  end

  rec_t mem [FIFO_DEPTH];
  rec_t rec_nx, head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, pop, push, drop;

  assign rec_nx = '{incomplete: incomplete, wt: wt_nx, stall: stall_nx,
                    iters: iters_nx, rdy: rdy_nx, lat: lat_nx};
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = rec_valid && rec_ready;
  assign push   = commit && (!full || pop);
  assign drop   = commit && full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rec_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      txn_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      txn_count  <= inc_c(txn_count, push);
      drop_count <= inc_c(drop_count, drop);
    end
  end

  // Head fields are gated so an empty FIFO (including during reset) reads as zero.
  assign head           = mem[rd_ptr[AW-1:0]];
  assign rec_valid      = !empty;
  assign rec_latency    = rec_valid ? head.lat : '0;
  assign rec_ready_cyc  = rec_valid ? head.rdy : '0;
  assign rec_iters      = rec_valid ? head.iters : '0;
  assign rec_stall      = rec_valid ? head.stall : '0;
  assign rec_wait       = rec_valid ? head.wt : '0;
  assign rec_incomplete = rec_valid ? head.incomplete : 1'b0;

endmodule

// File: tb/tb_ap_hs_txn_profiler.sv
// tb/tb_ap_hs_txn_profiler.sv - directed table-driven bench for ap_hs_txn_profiler
module tb_ap_hs_txn_profiler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
  logic        iter_fire = 1'b0, finish = 1'b0, rec_ready = 1'b0;
  logic        rec_valid, rec_incomplete, busy;
  logic [31:0] rec_latency, rec_ready_cyc, rec_stall, rec_wait, txn_count, drop_count;
  logic [15:0] rec_iters;

  int checks = 0;
  int errors = 0;

  ap_hs_txn_profiler #(.CNT_W(32), .ITER_W(16), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .iter_fire(iter_fire), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_latency(rec_latency), .rec_ready_cyc(rec_ready_cyc), .rec_iters(rec_iters),
    .rec_stall(rec_stall), .rec_wait(rec_wait), .rec_incomplete(rec_incomplete),
    .txn_count(txn_count), .drop_count(drop_count), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    int done_at; int rdy_at; int it_lo; int it_hi; int cont_low;
    int e_lat; int e_rdy; int e_iter; int e_stall; int e_wait;
  } vec_t;

  vec_t vt [5];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_txn(input int done_at, input int rdy_at, input int it_lo,
                         input int it_hi, input int cont_low);
    for (int c = 0; c <= done_at + cont_low; c++) begin
      ap_start    = (c == 0);
      ap_ready    = (c == rdy_at);
      iter_fire   = (c >= it_lo) && (c <= it_hi);
      ap_done     = (c >= done_at);
      ap_continue = (c >= done_at + cont_low);
      step();
    end
    ap_start = 0; ap_ready = 0; iter_fire = 0; ap_done = 0; ap_continue = 0;
  endtask

  task automatic pop_one();
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  initial begin
    int exp_lat [4];
    vt[0] = '{10,  2, 1, 8, 0,  11, 3, 8, 3, 0};
    vt[1] = '{ 5, -1, 1, 0, 4,   6, 0, 0, 6, 5};
    vt[2] = '{ 0,  0, 0, 0, 0,   1, 1, 1, 0, 0};
    vt[3] = '{ 3,  3, 0, 3, 2,   4, 4, 4, 0, 3};
    vt[4] = '{ 0, -1, 2, 5, 3,   1, 0, 0, 1, 4};
    exp_lat = '{2, 3, 4, 1};

    step(); step();
    chk("reset_valid", rec_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_txn", txn_count, 0);
    chk("reset_latency", rec_latency, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_txn(vt[i].done_at, vt[i].rdy_at, vt[i].it_lo, vt[i].it_hi, vt[i].cont_low);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_valid", i), rec_valid, 1);
      chk($sformatf("v%0d_latency", i), rec_latency, vt[i].e_lat);
      chk($sformatf("v%0d_ready_cyc", i), rec_ready_cyc, vt[i].e_rdy);
      chk($sformatf("v%0d_iters", i), rec_iters, vt[i].e_iter);
      chk($sformatf("v%0d_stall", i), rec_stall, vt[i].e_stall);
      chk($sformatf("v%0d_wait", i), rec_wait, vt[i].e_wait);
      chk($sformatf("v%0d_incomplete", i), rec_incomplete, 0);
      chk($sformatf("v%0d_txn", i), txn_count, i + 1);
      pop_one();
      chk($sformatf("v%0d_empty", i), rec_valid, 0);
    end

    // Overflow: six commits into a 4-deep FIFO with no reader.
    for (int k = 0; k < 6; k++) run_txn(k, -1, 1, 0, 0);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_txn", txn_count, 9);
    chk("ovf_head_held", rec_latency, 1);
    ap_start = 1; ap_done = 1; ap_continue = 1; rec_ready = 1;
    step();
    ap_start = 0; ap_done = 0; ap_continue = 0; rec_ready = 0;
    chk("ovf_pushpop_drop", drop_count, 2);
    chk("ovf_pushpop_txn", txn_count, 10);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), rec_valid, 1);
      chk($sformatf("drain%0d_latency", i), rec_latency, exp_lat[i]);
      pop_one();
    end
    chk("drain_empty", rec_valid, 0);

    // Finish on the 7th RUN cycle truncates the record.
    ap_start = 1;
    step();
    ap_start = 0;
    for (int c = 1; c < 7; c++) step();
    finish = 1;
    step();
    chk("fin_busy", busy, 0);
    chk("fin_valid", rec_valid, 1);
    chk("fin_latency", rec_latency, 8);
    chk("fin_incomplete", rec_incomplete, 1);
    chk("fin_stall", rec_stall, 8);
    chk("fin_txn", txn_count, 11);
    pop_one();
    finish = 0;
    run_txn(0, 0, 0, 0, 0);
    run_txn(2, -1, 0, 2, 0);
    chk("post_fin_valid", rec_valid, 0);
    chk("post_fin_txn", txn_count, 11);
    chk("post_fin_busy", busy, 0);

    // Async reset mid-transaction with two records queued.
    reset = 1; step(); reset = 0; step();
    run_txn(0, -1, 1, 0, 0);
    run_txn(1, -1, 1, 0, 0);
    chk("pre_rst_txn", txn_count, 2);
    ap_start = 1;
    step();
    ap_start = 0;
    step();
    chk("pre_rst_busy", busy, 1);
    #2;
    reset = 1;
    #1;
    chk("rst_async_valid", rec_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_txn", txn_count, 0);
    chk("rst_async_latency", rec_latency, 0);
    step();
    reset = 0;
    step();
    run_txn(vt[0].done_at, vt[0].rdy_at, vt[0].it_lo, vt[0].it_hi, vt[0].cont_low);
    chk("post_rst_latency", rec_latency, 11);
    chk("post_rst_ready_cyc", rec_ready_cyc, 3);
    chk("post_rst_iters", rec_iters, 8);
    chk("post_rst_txn", txn_count, 1);
    pop_one();
    chk("post_rst_empty", rec_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
